// File: rtl/ejtag_pkg.sv
// Shared EJTAG definitions: TAP state encoding, instruction codes and IR width.
// Also used by the EJTAG scan block so both agree on instruction ownership.
package ejtag_pkg;

    localparam int IR_WIDTH = 5;

    typedef enum logic [3:0] {
        TAP_TLR      = 4'd0,
        TAP_RTI      = 4'd1,
        TAP_SEL_DR   = 4'd2,
        TAP_CAP_DR   = 4'd3,
        TAP_SH_DR    = 4'd4,
        TAP_EX1_DR   = 4'd5,
        TAP_PAUSE_DR = 4'd6,
        TAP_EX2_DR   = 4'd7,
        TAP_UPD_DR   = 4'd8,
        TAP_SEL_IR   = 4'd9,
        TAP_CAP_IR   = 4'd10,
        TAP_SH_IR    = 4'd11,
        TAP_EX1_IR   = 4'd12,
        TAP_PAUSE_IR = 4'd13,
        TAP_EX2_IR   = 4'd14,
        TAP_UPD_IR   = 4'd15
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] INSTR_IDCODE   = 5'b00001;
    localparam logic [IR_WIDTH-1:0] INSTR_IMPCODE  = 5'b00011;
    localparam logic [IR_WIDTH-1:0] INSTR_ADDRESS  = 5'b01000;
    localparam logic [IR_WIDTH-1:0] INSTR_DATA     = 5'b01001;
    localparam logic [IR_WIDTH-1:0] INSTR_CONTROL  = 5'b01010;
    localparam logic [IR_WIDTH-1:0] INSTR_ALL      = 5'b01011;
    localparam logic [IR_WIDTH-1:0] INSTR_FASTDATA = 5'b10000;
    localparam logic [IR_WIDTH-1:0] INSTR_BYPASS   = 5'b11111;

    // True for codes whose data register lives in the external scan block.
    function automatic logic is_ejtag_code(input logic [IR_WIDTH-1:0] ir);
        logic hit;
        case (ir)
            INSTR_IMPCODE, INSTR_ADDRESS, INSTR_DATA,
            INSTR_CONTROL, INSTR_ALL, INSTR_FASTDATA: hit = 1'b1;
            default:                                  hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/ejtag_tap_fsm.sv
// 16-state 1149.1 TAP state machine with Moore strobe decode.
// Strobes depend only on the state register, never on TMS.
module ejtag_tap_fsm
    import ejtag_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tms,
    output tap_state_e state_q,
    output tap_state_e state_d,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr,
    output logic       runtest,
    output logic       capture_ir,
    output logic       shift_ir,
    output logic       update_ir
);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TAP_TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state transitions on TMS
    always_comb begin
        state_d = state_q;
        case (state_q)
            TAP_TLR:      state_d = tms ? TAP_TLR      : TAP_RTI;
            TAP_RTI:      state_d = tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_DR:   state_d = tms ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   state_d = tms ? TAP_EX1_DR   : TAP_SH_DR;
            TAP_SH_DR:    state_d = tms ? TAP_EX1_DR   : TAP_SH_DR;
            TAP_EX1_DR:   state_d = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: state_d = tms ? TAP_EX2_DR   : TAP_PAUSE_DR;
            TAP_EX2_DR:   state_d = tms ? TAP_UPD_DR   : TAP_SH_DR;
            TAP_UPD_DR:   state_d = tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_IR:   state_d = tms ? TAP_TLR      : TAP_CAP_IR;
            TAP_CAP_IR:   state_d = tms ? TAP_EX1_IR   : TAP_SH_IR;
            TAP_SH_IR:    state_d = tms ? TAP_EX1_IR   : TAP_SH_IR;
            TAP_EX1_IR:   state_d = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: state_d = tms ? TAP_EX2_IR   : TAP_PAUSE_IR;
            TAP_EX2_IR:   state_d = tms ? TAP_UPD_IR   : TAP_SH_IR;
            TAP_UPD_IR:   state_d = tms ? TAP_SEL_DR   : TAP_RTI;
            default:      state_d = TAP_TLR;
        endcase
    end

    // Moore strobe decode from the state register
    always_comb begin
        capture_dr = 1'b0;
        shift_dr   = 1'b0;
        update_dr  = 1'b0;
        runtest    = 1'b0;
        capture_ir = 1'b0;
        shift_ir   = 1'b0;
        update_ir  = 1'b0;
        case (state_q)
            TAP_RTI:    runtest    = 1'b1;
            TAP_CAP_DR: capture_dr = 1'b1;
            TAP_SH_DR:  shift_dr   = 1'b1;
            TAP_UPD_DR: update_dr  = 1'b1;
            TAP_CAP_IR: capture_ir = 1'b1;
            TAP_SH_IR:  shift_ir   = 1'b1;
            TAP_UPD_IR: update_ir  = 1'b1;
            default:    runtest    = 1'b0;
        endcase
    end

endmodule

// File: rtl/ejtag_tap_ctrl.sv
// EJTAG TAP controller: instruction register, IDCODE/BYPASS data registers
// and the TDO mux in front of the external EJTAG scan chain.
module ejtag_tap_ctrl
    import ejtag_pkg::*;
#(
    parameter logic [31:0] IDCODE_VALUE = 32'h0000_0001
) (
    input  logic                JTAG_CLOCK,
    input  logic                RESET_D1_JR,
    input  logic                JTAG_TMS,
    input  logic                JTAG_TDI,
    input  logic                JTAG_ESCANOUT,
    output logic                JTAG_ESCANIN,
    output logic [IR_WIDTH-1:0] JTAG_IR,
    output logic                JTAG_CAPTURE,
    output logic                JTAG_SHIFT,
    output logic                JTAG_UPDATE,
    output logic                JTAG_RUNTEST,
    output logic                JTAG_TDO,
    output logic                JTAG_TDO_EN
);

    tap_state_e          state_s;
    tap_state_e          next_state_s;
    logic                capture_dr_s, shift_dr_s, update_dr_s, runtest_s;
    logic                capture_ir_s, shift_ir_s, update_ir_s;

    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
    logic [31:0]         idcode_sr_q, idcode_sr_d;
    logic                bypass_q, bypass_d;
    logic                ir_is_idcode_s;

    ejtag_tap_fsm u_fsm (
        .clk        (JTAG_CLOCK),
        .rst        (RESET_D1_JR),
        .tms        (JTAG_TMS),
        .state_q    (state_s),
        .state_d    (next_state_s),
        .capture_dr (capture_dr_s),
        .shift_dr   (shift_dr_s),
        .update_dr  (update_dr_s),
        .runtest    (runtest_s),
        .capture_ir (capture_ir_s),
        .shift_ir   (shift_ir_s),
        .update_ir  (update_ir_s)
    );

    assign ir_is_idcode_s = (ir_q == INSTR_IDCODE);

    // Next values for IR and IDCODE registers; entering TLR reinitialises them
    always_comb begin
        ir_d        = ir_q;
        ir_sr_d     = ir_sr_q;
        idcode_sr_d = idcode_sr_q;
        if (next_state_s == TAP_TLR) begin
            ir_d        = INSTR_IDCODE;
            ir_sr_d     = INSTR_IDCODE;
            idcode_sr_d = IDCODE_VALUE;
        end else begin
            if (update_ir_s) begin
                ir_d = ir_sr_q;
            end else begin
                ir_d = ir_q;
            end
            if (capture_ir_s) begin
                ir_sr_d = INSTR_IDCODE;
            end else if (shift_ir_s) begin
                ir_sr_d = {JTAG_TDI, ir_sr_q[IR_WIDTH-1:1]};
            end else begin
                ir_sr_d = ir_sr_q;
            end
            if (capture_dr_s && ir_is_idcode_s) begin
                idcode_sr_d = IDCODE_VALUE;
            end else if (shift_dr_s && ir_is_idcode_s) begin
                idcode_sr_d = {JTAG_TDI, idcode_sr_q[31:1]};
            end else begin
                idcode_sr_d = idcode_sr_q;
            end
        end
    end

    // Bypass bit: captures 0, then follows TDI while shifting
    always_comb begin
        if (capture_dr_s) begin
            bypass_d = 1'b0;
        end else if (shift_dr_s) begin
            bypass_d = JTAG_TDI;
        end else begin
            bypass_d = bypass_q;
        end
    end

    // Data and instruction registers
    always_ff @(posedge JTAG_CLOCK or posedge RESET_D1_JR) begin
        if (RESET_D1_JR) begin
            ir_q        <= INSTR_IDCODE;
            ir_sr_q     <= INSTR_IDCODE;
            idcode_sr_q <= IDCODE_VALUE;
            bypass_q    <= 1'b0;
        end else begin
            ir_q        <= ir_d;
            ir_sr_q     <= ir_sr_d;
            idcode_sr_q <= idcode_sr_d;
            bypass_q    <= bypass_d;
        end
    end

    // TDO mux; pad logic retimes it to the falling edge
    always_comb begin
        JTAG_TDO = 1'b0;
        if (shift_ir_s) begin
            JTAG_TDO = ir_sr_q[0];
        end else if (shift_dr_s) begin
            if (is_ejtag_code(ir_q)) begin
                JTAG_TDO = JTAG_ESCANOUT;
            end else if (ir_is_idcode_s) begin
                JTAG_TDO = idcode_sr_q[0];
            end else begin
                JTAG_TDO = bypass_q;
            end
        end else begin
            JTAG_TDO = 1'b0;
        end
    end

    assign JTAG_ESCANIN = JTAG_TDI;
    assign JTAG_IR      = ir_q;
    assign JTAG_CAPTURE = capture_dr_s;
    assign JTAG_SHIFT   = shift_dr_s;
    assign JTAG_UPDATE  = update_dr_s;
    assign JTAG_RUNTEST = runtest_s;
    assign JTAG_TDO_EN  = shift_dr_s | shift_ir_s;

endmodule

// File: doc/ejtag_tap_ctrl.md
# ejtag_tap_ctrl

IEEE 1149.1 TAP controller that sequences the EJTAG scan-register datapath. It decodes TMS into the 16-state TAP state machine and holds the 5-bit instruction register. It drives the capture/shift/update/run-test strobes and instruction code consumed by the EJTAG scan block, and muxes TDO between the EJTAG chain, IDCODE and BYPASS. It sits between the JTAG pins (after synchronisation) and the EJTAG scan registers.

## Interface
Parameters:
- IDCODE_VALUE, 32'h0000_0001, device ID captured in Capture-DR under IDCODE; bit 0 must be 1.

Ports:
- JTAG_CLOCK  in  1  TCK; all state updates on its rising edge.
- RESET_D1_JR  in  1  Reset; asynchronous, active-high.
- JTAG_TMS  in  1  test mode select.
- JTAG_TDI  in  1  serial data in.
- JTAG_ESCANOUT  in  1  serial out of EJTAG scan chain.
- JTAG_ESCANIN  out  1  serial in to EJTAG scan chain (= JTAG_TDI).
- JTAG_IR  out  5  latched instruction.
- JTAG_CAPTURE  out  1  high in Capture-DR.
- JTAG_SHIFT  out  1  high in Shift-DR.
- JTAG_UPDATE  out  1  high in Update-DR.
- JTAG_RUNTEST  out  1  high in Run-Test/Idle.
- JTAG_TDO  out  1  serial data out.
- JTAG_TDO_EN  out  1  high in Shift-DR or Shift-IR.

## Operation
- TAP states: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR. Transitions follow 1149.1 exactly on TMS at each rising edge.
- Instructions: IDCODE 5'b00001, EJTAG codes 00011/01000/01001/01010/01011/10000, BYPASS 5'b11111. Any other code behaves as BYPASS.
- IR shift register (5b): CapIR loads 5'b00001. ShIR shifts right with TDI into bit 4 and bit 0 presented on TDO. UpdIR copies it to JTAG_IR.
- TLR forces JTAG_IR = 5'b00001, and the IR shift register and IDCODE shift register to their capture values.
- IDCODE DR (32b): CapDR with IR=IDCODE loads IDCODE_VALUE. ShDR shifts right, TDI into bit 31.
- BYPASS DR (1b): CapDR loads 0. ShDR loads TDI.
- EJTAG codes: the DR is external. This block only strobes it; the scan block loads on the rising edge leaving CapDR/ShDR.
- TDO mux:
  - ShIR: IR shift bit 0.
  - ShDR with an EJTAG code: JTAG_ESCANOUT.
  - ShDR with IDCODE: IDCODE shift bit 0.
  - ShDR otherwise: bypass bit.
  - Elsewhere: 0.
- Strobes are asserted regardless of IR. The scan block ignores codes it does not own.

## Timing
- Reset values: state TLR, JTAG_IR=5'b00001, all strobes 0, JTAG_TDO=0, JTAG_TDO_EN=0, bypass=0.
- Strobes and JTAG_TDO_EN are Moore outputs decoded from the state register. They are valid for the whole cycle spent in the state, with no combinational path from TMS.
- JTAG_TDO is combinational from registers plus JTAG_ESCANOUT. Pad logic retimes it to the falling edge.
- JTAG_IR changes only on the rising edge leaving UpdIR, or on entry to TLR. It is stable throughout any DR sequence.
- Five consecutive TMS=1 clocks reach TLR from any state.
- Reset asserted mid-shift aborts immediately to reset values; no UPDATE strobe is issued.
- Pause/Exit2 loops hold the shift registers with no shift; SHIFT=0 there.

## Structure
- Shared package `ejtag_pkg`:
  - 4-bit TAP state encoding.
  - 5-bit instruction codes (shared with the EJTAG scan block).
  - IR width constant.
- Sub-module `ejtag_tap_fsm`: state register plus next-state logic plus strobe decode.
- Parent `ejtag_tap_ctrl`: holds the IR, IDCODE and BYPASS registers and the TDO mux.

## Test plan
- Reset, then TMS=0 for 1 clock -> state RTI, JTAG_RUNTEST=1, JTAG_IR=00001, other strobes 0.
- From ShDR, TMS=1 for 5 clocks -> TLR; JTAG_IR=00001; a subsequent IDCODE scan of 32 bits returns IDCODE_VALUE LSB first.
- Load IR=01001, then run a DR scan with 32 shifts -> CAPTURE high 1 cycle, SHIFT high 32 cycles, UPDATE high 1 cycle; TDO equals the JTAG_ESCANOUT stimulus; JTAG_ESCANIN equals TDI.
- IR=5'b10101 (unused): shift TDI pattern 1011 -> TDO returns 0 then 1011, delayed one cycle.
- IR scan, shifting in 10000 -> TDO returns captured 10000 bit-reversed, i.e. 1,0,0,0,0 LSB-first from 00001. After UpdIR, JTAG_IR=10000; in RTI, JTAG_RUNTEST=1.
- Assert RESET_D1_JR during ShDR with IR=01011 -> all strobes 0 immediately, JTAG_IR=00001, no UPDATE pulse.
